// File: rtl/multi_cont_soma.sv
// multi_cont_soma: N_CH modulo counters with per-channel wrap pulses,
// a registered sum of all counts and a peak-hold register on that sum.
module multi_cont_soma #(
   parameter int WIDTH   = 6,
   parameter int N_CH    = 2,
   parameter int MODULUS = 64,
   localparam int SUM_W  = ($clog2(N_CH) < 1) ? WIDTH + 1
                                              : WIDTH + $clog2(N_CH)
) (
   input  logic                    clk,
   input  logic                    clr_n,
   input  logic [N_CH-1:0]         sclr_n,
   input  logic [N_CH-1:0]         en,
   input  logic [N_CH-1:0]         dn,
   input  logic                    pk_clr,
   output logic [N_CH*WIDTH-1:0]   cnt,
   output logic [N_CH-1:0]         wrap,
   output logic [SUM_W-1:0]        soma,
   output logic [SUM_W-1:0]        soma_pk
);

   localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q [N_CH];
   logic [N_CH-1:0]  wrap_q;
   logic [SUM_W-1:0] sum_d;
   logic [SUM_W-1:0] soma_q;
   logic [SUM_W-1:0] pk_q;

   // Channel counters: clear beats enable, wrap pulses on the wrapped value
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= '0;
         end
         wrap_q <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (!sclr_n[i]) begin
               cnt_q[i]  <= '0;
               wrap_q[i] <= 1'b0;
            end else if (en[i] && !dn[i]) begin
               if (cnt_q[i] == TOP) begin
                  cnt_q[i]  <= '0;
                  wrap_q[i] <= 1'b1;
               end else begin
                  cnt_q[i]  <= cnt_q[i] + ONE;
                  wrap_q[i] <= 1'b0;
               end
            end else if (en[i]) begin
               if (cnt_q[i] == '0) begin
                  cnt_q[i]  <= TOP;
                  wrap_q[i] <= 1'b1;
               end else begin
                  cnt_q[i]  <= cnt_q[i] - ONE;
                  wrap_q[i] <= 1'b0;
               end
            end else begin
               wrap_q[i] <= 1'b0;
            end
         end
      end
   end

   // Zero-extended sum of the current channel counts
   always_comb begin
      sum_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         sum_d = sum_d + SUM_W'(cnt_q[i]);
      end
   end

   // Sum register: one cycle behind the counters
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         soma_q <= '0;
      end else begin
         soma_q <= sum_d;
      end
   end

   // Peak hold on the registered sum; a clear wins over a new maximum
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         pk_q <= '0;
      end else if (pk_clr) begin
         pk_q <= '0;
      end else if (soma_q > pk_q) begin
         pk_q <= soma_q;
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_pack
      assign cnt[g*WIDTH +: WIDTH] = cnt_q[g];
   end

   assign wrap    = wrap_q;
   assign soma    = soma_q;
   assign soma_pk = pk_q;

endmodule

// File: tb/tb_multi_cont_soma.sv
// tb_multi_cont_soma: directed vector table plus hand sequences for
// reset, full up-wrap and asynchronous reset during counting.
module tb_multi_cont_soma;

   logic        clk;
   logic        clr_n;
   logic [1:0]  sclr_n;
   logic [1:0]  en;
   logic [1:0]  dn;
   logic        pk_clr;
   logic [11:0] cnt;
   logic [1:0]  wrap;
   logic [6:0]  soma;
   logic [6:0]  soma_pk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         reps;
      logic [1:0] sclr_n;
      logic [1:0] en;
      logic [1:0] dn;
      logic       pk_clr;
      int         c0;
      int         c1;
      int         wr;
      int         sm;
      int         pk;
   } vec_t;

   vec_t tbl [27];

   multi_cont_soma dut (
      .clk     (clk),
      .clr_n   (clr_n),
      .sclr_n  (sclr_n),
      .en      (en),
      .dn      (dn),
      .pk_clr  (pk_clr),
      .cnt     (cnt),
      .wrap    (wrap),
      .soma    (soma),
      .soma_pk (soma_pk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int c0, input int c1,
                          input int wr, input int sm, input int pk);
      chk({tag, " cnt0"}, 32'(cnt[5:0]), c0);
      chk({tag, " cnt1"}, 32'(cnt[11:6]), c1);
      chk({tag, " wrap"}, 32'(wrap), wr);
      chk({tag, " soma"}, 32'(soma), sm);
      chk({tag, " soma_pk"}, 32'(soma_pk), pk);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reps, sclr_n, en, dn, pk_clr -> cnt0, cnt1, wrap, soma, soma_pk
      tbl[0]  = '{1,  2'b11, 2'b10, 2'b10, 1'b0, 0,  63, 2, 0,   63};
      tbl[1]  = '{1,  2'b11, 2'b10, 2'b10, 1'b0, 0,  62, 0, 63,  63};
      tbl[2]  = '{1,  2'b11, 2'b00, 2'b00, 1'b0, 0,  62, 0, 62,  63};
      tbl[3]  = '{1,  2'b11, 2'b11, 2'b01, 1'b0, 63, 63, 1, 62,  63};
      tbl[4]  = '{1,  2'b11, 2'b00, 2'b00, 1'b0, 63, 63, 0, 126, 63};
      tbl[5]  = '{1,  2'b11, 2'b00, 2'b00, 1'b0, 63, 63, 0, 126, 126};
      tbl[6]  = '{1,  2'b00, 2'b11, 2'b11, 1'b0, 0,  0,  0, 126, 126};
      tbl[7]  = '{1,  2'b11, 2'b00, 2'b00, 1'b0, 0,  0,  0, 0,   126};
      tbl[8]  = '{1,  2'b11, 2'b00, 2'b00, 1'b1, 0,  0,  0, 0,   0};
      tbl[9]  = '{10, 2'b11, 2'b01, 2'b00, 1'b0, 10, 0,  0, 9,   8};
      tbl[10] = '{1,  2'b10, 2'b11, 2'b00, 1'b0, 0,  1,  0, 10,  9};
      tbl[11] = '{1,  2'b11, 2'b10, 2'b00, 1'b0, 0,  2,  0, 1,   10};
      tbl[12] = '{1,  2'b11, 2'b00, 2'b00, 1'b0, 0,  2,  0, 2,   10};
      tbl[13] = '{48, 2'b11, 2'b01, 2'b00, 1'b0, 48, 2,  0, 49,  48};
      tbl[14] = '{1,  2'b11, 2'b00, 2'b00, 1'b0, 48, 2,  0, 50,  49};
      tbl[15] = '{1,  2'b11, 2'b00, 2'b00, 1'b0, 48, 2,  0, 50,  50};
      tbl[16] = '{1,  2'b00, 2'b00, 2'b00, 1'b0, 0,  0,  0, 50,  50};
      tbl[17] = '{1,  2'b11, 2'b00, 2'b00, 1'b0, 0,  0,  0, 0,   50};
      tbl[18] = '{1,  2'b11, 2'b01, 2'b01, 1'b0, 63, 0,  1, 0,   50};
      tbl[19] = '{1,  2'b11, 2'b00, 2'b00, 1'b0, 63, 0,  0, 63,  50};
      tbl[20] = '{1,  2'b11, 2'b00, 2'b00, 1'b1, 63, 0,  0, 63,  0};
      tbl[21] = '{1,  2'b11, 2'b00, 2'b00, 1'b0, 63, 0,  0, 63,  63};
      tbl[22] = '{1,  2'b11, 2'b10, 2'b00, 1'b0, 63, 1,  0, 63,  63};
      tbl[23] = '{1,  2'b11, 2'b10, 2'b10, 1'b0, 63, 0,  0, 64,  63};
      tbl[24] = '{1,  2'b11, 2'b10, 2'b10, 1'b0, 63, 63, 2, 63,  64};
      tbl[25] = '{1,  2'b11, 2'b11, 2'b00, 1'b0, 0,  0,  3, 126, 64};
      tbl[26] = '{1,  2'b11, 2'b00, 2'b00, 1'b0, 0,  0,  0, 0,   126};

      clr_n  = 1'b0;
      sclr_n = 2'b11;
      en     = 2'b11;
      dn     = 2'b00;
      pk_clr = 1'b0;
      #1;
      chk_all("reset async", 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all($sformatf("reset hold %0d", i), 0, 0, 0, 0, 0);
      end
      clr_n = 1'b1;
      en    = 2'b00;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all($sformatf("reset idle %0d", i), 0, 0, 0, 0, 0);
      end

      en = 2'b01;
      dn = 2'b00;
      for (int k = 1; k <= 64; k++) begin
         step();
         chk_all($sformatf("upwrap %0d", k), k % 64, 0,
                 (k == 64) ? 1 : 0, k - 1, (k < 2) ? 0 : k - 2);
      end
      en = 2'b00;
      step();
      chk_all("upwrap idle", 0, 0, 0, 0, 63);

      for (int v = 0; v < 27; v++) begin
         sclr_n = tbl[v].sclr_n;
         en     = tbl[v].en;
         dn     = tbl[v].dn;
         pk_clr = tbl[v].pk_clr;
         for (int r = 0; r < tbl[v].reps; r++) begin
            step();
         end
         chk_all($sformatf("vec %0d", v), tbl[v].c0, tbl[v].c1,
                 tbl[v].wr, tbl[v].sm, tbl[v].pk);
      end

      sclr_n = 2'b11;
      pk_clr = 1'b0;
      en     = 2'b01;
      dn     = 2'b00;
      for (int i = 0; i < 5; i++) begin
         step();
      end
      chk_all("pre midreset", 5, 0, 0, 4, 126);
      #2;
      clr_n = 1'b0;
      #1;
      chk_all("midreset async", 0, 0, 0, 0, 0);
      step();
      chk_all("midreset held", 0, 0, 0, 0, 0);
      clr_n = 1'b1;
      step();
      chk_all("midreset release", 1, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_cont_soma.md
Name: multi_cont_soma

Overview:
- N_CH independent modulo-MODULUS counters, WIDTH bits each. Every channel has its own enable, direction and synchronous clear.
- A registered adder sums all channel counts. A peak register holds the largest sum seen.
- Generalised successor of the fixed two-channel 6-bit counter-plus-adder top. It feeds display and monitoring logic in the FPGA exercises.

Parameters:
- WIDTH, 6, bits per channel counter.
- N_CH, 2, number of counter channels (1..16).
- MODULUS, 64, count modulus per channel. Legal range 2..2^WIDTH; counts run 0..MODULUS-1.
- Derived, not overridable: SUM_W = WIDTH + clog2(N_CH), with a minimum of WIDTH+1. With the defaults SUM_W = 7.

Ports:
- clk, input, 1, system clock, rising edge.
- clr_n, input, 1, asynchronous active-low reset, global.
- sclr_n, input, N_CH, per-channel synchronous active-low clear.
- en, input, N_CH, per-channel count enable.
- dn, input, N_CH, per-channel direction: 0 = up, 1 = down.
- pk_clr, input, 1, synchronous clear of the peak register.
- cnt, output, N_CH*WIDTH, packed channel counts; channel i occupies cnt[i*WIDTH +: WIDTH].
- wrap, output, N_CH, per-channel wrap pulse.
- soma, output, SUM_W, registered sum of all channel counts.
- soma_pk, output, SUM_W, maximum soma value since the last clear.

Behaviour:
- Reset (clr_n=0, asynchronous, takes effect immediately and holds while low): cnt=0, wrap=0, soma=0, soma_pk=0.
- Reset released mid-operation: the first active edge after release follows the normal rules from the all-zero state.

Per-channel priority on each rising clk edge, highest first:
- sclr_n[i]=0: cnt_i <= 0 and wrap[i] <= 0. This applies regardless of en/dn.
- en[i]=1, dn[i]=0: if cnt_i == MODULUS-1, cnt_i <= 0 and wrap[i] <= 1; otherwise cnt_i <= cnt_i+1 and wrap[i] <= 0.
- en[i]=1, dn[i]=1: if cnt_i == 0, cnt_i <= MODULUS-1 and wrap[i] <= 1; otherwise cnt_i <= cnt_i-1 and wrap[i] <= 0.
- en[i]=0: cnt_i holds and wrap[i] <= 0.

Wrap and channel rules:
- wrap[i] is a one-cycle pulse, asserted in the same cycle the wrapped value appears on cnt_i.
- A direction change takes effect on the edge where dn is sampled; there is no pipeline.
- Channels are fully independent; simultaneous events on different channels do not interact.

Sum:
- soma <= sum over i of cnt_i, sampled on the same edge. This gives one cycle of latency from cnt to soma.
- Zero-extended unsigned arithmetic at width SUM_W. Overflow is impossible: max = N_CH*(MODULUS-1) < 2^SUM_W.
- A synchronous clear is visible on soma one cycle after it is visible on cnt.

Peak:
- If pk_clr=1: soma_pk <= 0.
- Else if soma > soma_pk: soma_pk <= soma. Otherwise it holds.
- soma_pk therefore lags soma by one cycle.
- If pk_clr and a new maximum occur on the same edge, pk_clr wins; the next edge recaptures the maximum if soma is still larger.

Implementation and non-goals:
- Fully synchronous datapath apart from clr_n. No combinational path from any input to any output.
- No load input and no saturation mode.

Test Plan:
1. Reset check: hold clr_n=0 with en=2'b11, then deassert clr_n for 3 idle cycles (en=0). Required: cnt=0, soma=0, soma_pk=0, wrap=0 throughout.
2. Up wrap: ch0 en=1, dn=0 for 64 cycles from 0. Required: cnt0 goes 0..63 and then 0. wrap[0]=1 only in the cycle cnt0 returns to 0. soma tracks cnt0 one cycle later; soma_pk=63.
3. Down wrap: ch1 en=1, dn=1 from 0. Required: first edge gives cnt1=63 with wrap[1]=1; the next edge gives 62 with wrap[1]=0.
4. Sum maximum: both channels at 63, then idle one cycle. Required: soma=126 (7'h7E), no overflow, soma_pk=126 one cycle later.
5. Clear priority: ch0 at 10 with en=1 and sclr_n[0]=0 on the same edge; ch1 counting. Required: cnt0=0 and wrap[0]=0 while ch1 keeps counting; soma drops by 10 (plus ch1's increment) on the next cycle.
6. Peak clear collision: soma_pk=50, soma rising to 60, pk_clr=1 on that edge. Required: soma_pk=0, then 60 on the following edge with pk_clr=0.
